// File: rtl/truth_table_sequencer.sv
// Truth-table sequencer: sweeps every input vector of a small combinational
// block in binary order, holds each vector for DWELL cycles, and samples the
// block output at the end of the dwell. Each sample is compared against the
// golden table, and the results are kept until the next start or reset.
module truth_table_sequencer #(
    parameter int                         N_INPUTS = 4,
    parameter int                         DWELL    = 10,
    parameter logic [(1<<N_INPUTS)-1:0]   EXPECTED = 16'h6996
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      f_in,
    output logic [N_INPUTS-1:0]       vec,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [N_INPUTS:0]         err_count,
    output logic                      first_err_valid,
    output logic [N_INPUTS-1:0]       first_err_idx,
    output logic [(1<<N_INPUTS)-1:0]  captured
);

    localparam int                  V          = 1 << N_INPUTS;
    localparam int                  CW         = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0]       CNT_RELOAD = CW'(DWELL - 1);
    localparam logic [N_INPUTS-1:0] LAST_IDX   = N_INPUTS'(V - 1);
    localparam logic [N_INPUTS:0]   ERR_MAX    = (N_INPUTS + 1)'(V);
    localparam logic [N_INPUTS:0]   ERR_ONE    = (N_INPUTS + 1)'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [N_INPUTS-1:0]  idx;
    logic [CW-1:0]        cnt;
    logic                 sample;
    logic                 last;
    logic                 launch;
    logic                 mismatch;

    // Sample edge is the final cycle of the dwell; launch is a start honoured outside APPLY.
    always_comb begin
        sample   = (state == APPLY) && (cnt == '0);
        last     = (idx == LAST_IDX);
        launch   = start && (state != APPLY);
        mismatch = (f_in != EXPECTED[idx]);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = APPLY;
            APPLY:   if (sample && last) state_next = DONE;
            DONE:    if (start) state_next = APPLY;
            default: state_next = IDLE;
        endcase
    end

    // Index / dwell counter: a launch restarts at vector 0; each sample edge advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
            cnt <= '0;
        end else if (launch) begin
            idx <= '0;
            cnt <= CNT_RELOAD;
        end else if (state == APPLY) begin
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else if (!last) begin
                idx <= idx + 1'b1;
                cnt <= CNT_RELOAD;
            end
        end
    end

    // Result capture: cleared on launch, updated only on sample edges, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            captured        <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
        end else if (launch) begin
            captured        <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
        end else if (sample) begin
            captured[idx] <= f_in;
            if (mismatch) begin
                if (err_count != ERR_MAX) begin
                    err_count <= err_count + ERR_ONE;
                end
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_idx   <= idx;
                end
            end
        end
    end

    // Outputs decoded from state and the registered index.
    always_comb begin
        vec  = idx;
        busy = (state == APPLY);
        done = (state == DONE);
        pass = (state == DONE) && (err_count == '0);
    end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: two instances (DWELL=10 and DWELL=1) with
// behavioural function-block models on f_in. Stimulus pushes the expected
// end-of-sweep results into per-instance queues; monitors pop and compare
// when done rises, and also track vec stepping and busy length.
module tb_truth_table_sequencer;

    typedef struct {
        logic [15:0] cap;
        logic [4:0]  errc;
        logic        pass;
        logic        fev;
        logic [3:0]  fei;
        int          k;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start0, start1;
    logic        f0, f1;
    logic [3:0]  vec0, vec1;
    logic        busy0, busy1, done0, done1, pass0, pass1;
    logic [4:0]  errc0, errc1;
    logic        fev0, fev1;
    logic [3:0]  fei0, fei1;
    logic [15:0] cap0, cap1;

    int          mode;   // 0: xor4, 1: xor4 inverted at index 5, 2: tied 0
    int          cyc;
    int          k0, k1;
    int          checks;
    int          errors;
    exp_t        q0[$];
    exp_t        q1[$];

    truth_table_sequencer #(.N_INPUTS(4), .DWELL(10), .EXPECTED(16'h6996)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .f_in(f0), .vec(vec0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(errc0),
        .first_err_valid(fev0), .first_err_idx(fei0), .captured(cap0)
    );

    truth_table_sequencer #(.N_INPUTS(4), .DWELL(1), .EXPECTED(16'h6996)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .f_in(f1), .vec(vec1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(errc1),
        .first_err_valid(fev1), .first_err_idx(fei1), .captured(cap1)
    );

    assign f0 = (mode == 2) ? 1'b0 : ((^vec0) ^ ((mode == 1) && (vec0 == 4'd5)));
    assign f1 = ^vec1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic start_sweep0(input logic [15:0] cap, input logic [4:0] errc,
                                input logic ps, input logic fev, input logic [3:0] fei);
        exp_t e;
        k0 = cyc + 1;
        e.cap = cap; e.errc = errc; e.pass = ps; e.fev = fev; e.fei = fei; e.k = k0;
        q0.push_back(e);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic wait_done0();
        for (int i = 0; i < 400; i++) begin
            if (done0) break;
            @(negedge clk);
        end
        check("done0_timeout", {31'd0, done0}, 32'd1);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag, input logic [3:0] v, input logic b,
                                  input logic d, input logic p, input logic [4:0] ec,
                                  input logic fv, input logic [3:0] fi, input logic [15:0] c);
        check({tag, "_vec"}, {28'd0, v}, 32'd0);
        check({tag, "_busy"}, {31'd0, b}, 32'd0);
        check({tag, "_done"}, {31'd0, d}, 32'd0);
        check({tag, "_pass"}, {31'd0, p}, 32'd0);
        check({tag, "_errc"}, {27'd0, ec}, 32'd0);
        check({tag, "_fev"}, {31'd0, fv}, 32'd0);
        check({tag, "_fei"}, {28'd0, fi}, 32'd0);
        check({tag, "_cap"}, {16'd0, c}, 32'd0);
    endtask

    // Monitor for the DWELL=10 instance.
    initial begin
        int   bcnt;
        logic pd;
        exp_t e;
        bcnt = 0;
        pd   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bcnt = 0;
            end else begin
                if (busy0) begin
                    check("vec0_step", {28'd0, vec0}, 32'((cyc - k0) / 10));
                    bcnt++;
                end
                if (!done0) check("pass0_low", {31'd0, pass0}, 32'd0);
                if (done0 && !pd) begin
                    if (q0.size() == 0) begin
                        check("q0_nonempty", 32'd0, 32'd1);
                    end else begin
                        e = q0.pop_front();
                        check("dut0_done_cycle", 32'(cyc), 32'(e.k + 160));
                        check("dut0_busy_len", 32'(bcnt), 32'd160);
                        check("dut0_cap", {16'd0, cap0}, {16'd0, e.cap});
                        check("dut0_errc", {27'd0, errc0}, {27'd0, e.errc});
                        check("dut0_pass", {31'd0, pass0}, {31'd0, e.pass});
                        check("dut0_fev", {31'd0, fev0}, {31'd0, e.fev});
                        check("dut0_fei", {28'd0, fei0}, {28'd0, e.fei});
                        check("dut0_vec_hold", {28'd0, vec0}, 32'd15);
                    end
                    bcnt = 0;
                end
            end
            pd = done0;
        end
    end

    // Monitor for the DWELL=1 instance.
    initial begin
        int   bcnt;
        logic pd;
        exp_t e;
        bcnt = 0;
        pd   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bcnt = 0;
            end else begin
                if (busy1) begin
                    check("vec1_step", {28'd0, vec1}, 32'(cyc - k1));
                    bcnt++;
                end
                if (done1 && !pd) begin
                    if (q1.size() == 0) begin
                        check("q1_nonempty", 32'd0, 32'd1);
                    end else begin
                        e = q1.pop_front();
                        check("dut1_done_cycle", 32'(cyc), 32'(e.k + 16));
                        check("dut1_busy_len", 32'(bcnt), 32'd16);
                        check("dut1_cap", {16'd0, cap1}, {16'd0, e.cap});
                        check("dut1_errc", {27'd0, errc1}, {27'd0, e.errc});
                        check("dut1_pass", {31'd0, pass1}, {31'd0, e.pass});
                        check("dut1_fev", {31'd0, fev1}, {31'd0, e.fev});
                    end
                    bcnt = 0;
                end
            end
            pd = done1;
        end
    end

    initial begin
        exp_t e;
        checks = 0;
        errors = 0;
        mode   = 0;
        k0     = 0;
        k1     = 0;
        start0 = 1'b0;
        start1 = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_all_zero("rst", vec0, busy0, done0, pass0, errc0, fev0, fei0, cap0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Clean XOR4 sweep.
        mode = 0;
        start_sweep0(16'h6996, 5'd0, 1'b1, 1'b0, 4'd0);
        // start during APPLY must not restart or extend the sweep
        repeat (20) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done0();

        // Single inverted entry at index 5.
        mode = 1;
        start_sweep0(16'h69B6, 5'd1, 1'b0, 1'b1, 4'd5);
        wait_done0();

        // Output stuck at 0.
        mode = 2;
        start_sweep0(16'h0000, 5'd8, 1'b0, 1'b1, 4'd1);
        wait_done0();

        // Restart straight from DONE after a failing sweep; results clear on the start edge.
        mode = 0;
        start_sweep0(16'h6996, 5'd0, 1'b1, 1'b0, 4'd0);
        check("b2b_busy", {31'd0, busy0}, 32'd1);
        check("b2b_done", {31'd0, done0}, 32'd0);
        check("b2b_errc", {27'd0, errc0}, 32'd0);
        check("b2b_cap", {16'd0, cap0}, 32'd0);
        check("b2b_fev", {31'd0, fev0}, 32'd0);
        wait_done0();

        // Reset during vector 9 aborts and clears everything.
        mode = 2;
        start_sweep0(16'h0000, 5'd8, 1'b0, 1'b1, 4'd1);
        for (int i = 0; i < 200; i++) begin
            if (vec0 == 4'd9) break;
            @(negedge clk);
        end
        check("reach_vec9", {28'd0, vec0}, 32'd9);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst", vec0, busy0, done0, pass0, errc0, fev0, fei0, cap0);
        q0.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_busy", {31'd0, busy0}, 32'd0);
        check("post_rst_done", {31'd0, done0}, 32'd0);
        check("post_rst_vec", {28'd0, vec0}, 32'd0);
        mode = 0;
        start_sweep0(16'h6996, 5'd0, 1'b1, 1'b0, 4'd0);
        wait_done0();

        // DWELL=1 sweep with a stray start at k+7.
        k1 = cyc + 1;
        e.cap = 16'h6996; e.errc = 5'd0; e.pass = 1'b1; e.fev = 1'b0; e.fei = 4'd0; e.k = k1;
        q1.push_back(e);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        while (cyc < k1 + 6) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done1) break;
            @(negedge clk);
        end
        check("done1_timeout", {31'd0, done1}, 32'd1);
        repeat (3) @(negedge clk);
        check("done1_hold", {31'd0, done1}, 32'd1);
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
